// File: rtl/unit_clause_detector.sv
// Scans clause memory against the current assignment, pushes forced literals of unit
// clauses and aborts on the first falsified clause. UCD_DEDUP_EN enables per-variable push dedup.
module unit_clause_detector #(
  parameter int NUM_VARIABLE = 128,
  parameter int CLAUSE_IDX_W = 10,
  parameter int LITS         = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [CLAUSE_IDX_W-1:0] clause_count,
  input  logic [NUM_VARIABLE-1:0] assign_valid,
  input  logic [NUM_VARIABLE-1:0] assign_val,
  output logic                    mem_rd_en,
  output logic [CLAUSE_IDX_W-1:0] mem_addr,
  input  logic [LITS*10-1:0]      mem_rdata,
  output logic                    push_en,
  output logic                    push_rw,
  output logic                    push_val,
  output logic [8:0]              push_variable,
  output logic                    busy,
  output logic                    done,
  output logic                    conflict,
  output logic [CLAUSE_IDX_W-1:0] conflict_clause,
  output logic [10:0]             unit_count
);

  localparam int VIDX_W = (NUM_VARIABLE > 1) ? $clog2(NUM_VARIABLE) : 1;
  localparam int CNT_W  = $clog2(LITS + 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FINISH} state_t;

  state_t                  state_reg, state_next;
  logic [CLAUSE_IDX_W-1:0] count_reg;
  logic                    mem_rd_en_reg;
  logic [CLAUSE_IDX_W-1:0] mem_addr_reg;
  logic                    rd_valid_reg;
  logic [CLAUSE_IDX_W-1:0] data_addr_reg;
  logic                    push_en_reg;
  logic                    push_val_reg;
  logic [8:0]              push_variable_reg;
  logic                    conflict_reg;
  logic [CLAUSE_IDX_W-1:0] conflict_clause_reg;
  logic [10:0]             unit_count_reg;

  logic                    start_accept;
  logic                    last_read;
  logic                    conflict_now;
  logic                    do_push;

  // Per-slot literal evaluation
  logic [LITS-1:0]         slot_true;
  logic [LITS-1:0]         slot_unassigned;
  logic [LITS-1:0]         slot_neg;
  logic [LITS-1:0][8:0]    slot_var;

  genvar gi;
  generate
    for (gi = 0; gi < LITS; gi++) begin : g_slot
      logic [8:0]        var_w;
      logic              nonempty;
      logic [VIDX_W-1:0] idx;

      assign var_w         = mem_rdata[10*gi +: 9];
      assign slot_neg[gi]  = mem_rdata[10*gi + 9];
      assign slot_var[gi]  = var_w;
      assign nonempty      = (var_w != 9'd0) && (int'(var_w) <= NUM_VARIABLE);
      assign idx           = VIDX_W'(var_w - 9'd1);
      assign slot_true[gi] = nonempty && assign_valid[idx] && (assign_val[idx] != slot_neg[gi]);
      assign slot_unassigned[gi] = nonempty && !assign_valid[idx];
    end
  endgenerate

  logic [CNT_W-1:0] unassigned_cnt;
  logic [8:0]       unit_var;
  logic             unit_neg;
  logic             clause_sat;
  logic             clause_conflict;
  logic             clause_unit;

  // With exactly one unassigned slot the loop leaves that slot's literal selected.
  always_comb begin
    unassigned_cnt = '0;
    unit_var       = '0;
    unit_neg       = 1'b0;
    for (int k = 0; k < LITS; k++) begin
      if (slot_unassigned[k]) begin
        unassigned_cnt = unassigned_cnt + CNT_W'(1);
        unit_var       = slot_var[k];
        unit_neg       = slot_neg[k];
      end
    end
  end

  assign clause_sat      = |slot_true;
  assign clause_conflict = !clause_sat && (unassigned_cnt == '0);
  assign clause_unit     = !clause_sat && (unassigned_cnt == CNT_W'(1));

  logic dup_same;
  logic dup_opp;

`ifdef UCD_DEDUP_EN
  logic [NUM_VARIABLE-1:0] pushed_reg;
  logic [NUM_VARIABLE-1:0] polarity_reg;
  logic [VIDX_W-1:0]       unit_idx;

  assign unit_idx = VIDX_W'(unit_var - 9'd1);
  assign dup_same = clause_unit && pushed_reg[unit_idx] && (polarity_reg[unit_idx] == ~unit_neg);
  assign dup_opp  = clause_unit && pushed_reg[unit_idx] && (polarity_reg[unit_idx] != ~unit_neg);

  always_ff @(posedge clk) begin
    if (reset) begin
      pushed_reg   <= '0;
      polarity_reg <= '0;
    end else if (start_accept) begin
      pushed_reg   <= '0;
      polarity_reg <= '0;
    end else if (do_push) begin
      pushed_reg[unit_idx]   <= 1'b1;
      polarity_reg[unit_idx] <= ~unit_neg;
    end
  end
`else
  assign dup_same = 1'b0;
  assign dup_opp  = 1'b0;
`endif

  assign start_accept = (state_reg == IDLE) && start;
  assign last_read    = (mem_addr_reg == count_reg - CLAUSE_IDX_W'(1));
  assign conflict_now = rd_valid_reg && (clause_conflict || dup_opp);
  assign do_push      = rd_valid_reg && clause_unit && !dup_same && !dup_opp;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (clause_count == '0) ? FINISH : SCAN;
        end
      end
      SCAN: begin
        if (conflict_now)   state_next = FINISH;
        else if (last_read) state_next = DRAIN;
      end
      DRAIN: begin
        // Leave once the final clause has been classified (its push is already registered).
        if (conflict_now || !rd_valid_reg) state_next = FINISH;
      end
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      mem_rd_en_reg <= 1'b0;
      mem_addr_reg  <= '0;
      rd_valid_reg  <= 1'b0;
      data_addr_reg <= '0;
    end else begin
      state_reg     <= state_next;
      mem_rd_en_reg <= (state_next == SCAN);
      // Data returning for a read issued alongside a conflict is dropped here.
      rd_valid_reg  <= mem_rd_en_reg && !conflict_now;
      data_addr_reg <= mem_addr_reg;
      if (start_accept) begin
        count_reg    <= clause_count;
        mem_addr_reg <= '0;
      end else if ((state_reg == SCAN) && (state_next == SCAN)) begin
        mem_addr_reg <= mem_addr_reg + CLAUSE_IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      push_en_reg         <= 1'b0;
      push_val_reg        <= 1'b0;
      push_variable_reg   <= '0;
      conflict_reg        <= 1'b0;
      conflict_clause_reg <= '0;
      unit_count_reg      <= '0;
    end else begin
      push_en_reg <= do_push;
      if (do_push) begin
        push_val_reg      <= ~unit_neg;
        push_variable_reg <= unit_var;
      end
      if (start_accept) begin
        conflict_reg        <= 1'b0;
        conflict_clause_reg <= '0;
        unit_count_reg      <= '0;
      end else begin
        if (conflict_now) begin
          conflict_reg        <= 1'b1;
          conflict_clause_reg <= data_addr_reg;
        end
        if (do_push) unit_count_reg <= unit_count_reg + 11'd1;
      end
    end
  end

  assign mem_rd_en       = mem_rd_en_reg;
  assign mem_addr        = mem_addr_reg;
  assign push_en         = push_en_reg;
  assign push_rw         = 1'b1;
  assign push_val        = push_val_reg;
  assign push_variable   = push_variable_reg;
  assign busy            = (state_reg == SCAN) || (state_reg == DRAIN);
  assign done            = (state_reg == FINISH);
  assign conflict        = conflict_reg;
  assign conflict_clause = conflict_clause_reg;
  assign unit_count      = unit_count_reg;

endmodule

// File: doc/unit_clause_detector.md
# unit_clause_detector

Upstream producer for `imply_stack` in the DPLL solver datapath. Scans the clause memory against the current variable assignment, one clause per cycle. Each clause is classified as satisfied, unresolved, unit or conflicting. Every unit clause's forced literal is pushed into `imply_stack` as a write/push request, and the scan aborts with a conflict report on the first falsified clause.

## Interface
Parameters:
- `NUM_VARIABLE`, 128, number of solver variables; valid variable indices are 1..NUM_VARIABLE.
- `CLAUSE_IDX_W`, 10, clause address width (up to 1023 clauses).
- `LITS`, 5, literal slots per clause.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `start` in 1: begin a scan pass; sampled only when idle.
- `clause_count` in CLAUSE_IDX_W: number of clauses to scan; sampled with `start`.
- `assign_valid` in NUM_VARIABLE: bit v-1 set means variable v is assigned; must stay stable while `busy`.
- `assign_val` in NUM_VARIABLE: assigned value of variable v at bit v-1.
- `mem_rd_en` out 1: clause memory read strobe.
- `mem_addr` out CLAUSE_IDX_W: clause index being read.
- `mem_rdata` in LITS*10: clause data, returned one cycle after `mem_rd_en`. Slot k is bits [10k+9:10k], with bit 9 = negated and [8:0] = variable. Variable 0 or variable > NUM_VARIABLE marks an empty slot.
- `push_en` out 1: push strobe to `imply_stack` (its `en`).
- `push_rw` out 1: tied to 1 (push).
- `push_val` out 1: implied value.
- `push_variable` out 9: implied variable.
- `busy` out 1: scan in progress.
- `done` out 1: one-cycle pulse at end of pass.
- `conflict` out 1: pass ended on a falsified clause; held until the next `start`.
- `conflict_clause` out CLAUSE_IDX_W: index of the falsified clause.
- `unit_count` out 11: pushes issued this pass.

## Operation
- FSM states: IDLE, SCAN, DRAIN, FINISH.
  - IDLE → SCAN on `start`. If `clause_count`==0, IDLE → FINISH instead.
  - SCAN issues reads at addresses 0..clause_count-1, one per cycle. It goes to DRAIN after the last read is issued.
  - DRAIN waits for the last data and its push.
  - FINISH pulses `done`, then returns to IDLE.
- `start` clears `conflict`, `conflict_clause` and `unit_count`. `start` while busy is ignored.
- Per non-empty literal slot:
  - The literal is true if the variable is assigned and `assign_val` != negated.
  - The literal is false if the variable is assigned and `assign_val` == negated.
  - Otherwise the literal is unassigned.
- Clause classification:
  - Any true literal: satisfied, no action.
  - Otherwise, zero unassigned literals: conflict. An all-empty clause also counts as a conflict.
  - Otherwise, exactly one unassigned literal: unit. Push `push_variable`=var and `push_val`=~negated, and increment `unit_count`.
  - Otherwise (two or more unassigned): no action.
- Duplicate slots of the same variable are counted independently. The clause generator guarantees there are none.
- On conflict: set `conflict`, latch `conflict_clause`, and stop issuing reads. Any clause data already in flight is discarded without a push. Then go to FINISH.
- Pushes are not fed back into the assignment within a pass; the controller re-runs the pass. `imply_stack` has no full flag, so the controller sizes it at ≥ clause count.

## Timing
- Reset values: `mem_rd_en`=0, `mem_addr`=0, `push_en`=0, `push_val`=0, `push_variable`=0, `busy`=0, `done`=0, `conflict`=0, `conflict_clause`=0, `unit_count`=0. `push_rw` is constant 1.
- Reset mid-pass returns to IDLE next cycle. No further reads or pushes occur.
- With `start` sampled at cycle 0 and N = clause_count:
  - `busy`=1 from cycle 1.
  - Clause i: `mem_addr`=i with `mem_rd_en`=1 at cycle 1+i, `mem_rdata` at 2+i, registered push at 3+i.
  - Throughput is 1 clause/cycle; latency is 2 cycles from read to push.
- Normal end: `done`=1 and `busy`=0 at cycle N+3.
- Conflict at clause c: `conflict`=1 and `done`=1 at cycle 3+c. `mem_rd_en`=0 from cycle 3+c. The read of clause c+1 at cycle 2+c is discarded.
- N=0: `done` at cycle 1, no reads.

## Configuration
- `UCD_DEDUP_EN` defined: a NUM_VARIABLE-bit pushed bitmap and a polarity bitmap, both cleared on `start`.
  - A second unit for an already-pushed variable with the same value is suppressed: no push, no count.
  - A second unit with the opposite value is a conflict at that clause.
- `UCD_DEDUP_EN` undefined: every unit clause pushes; no bitmaps exist.

## Test plan
- All variables unassigned, 3 clauses of 2+ literals, start → no pushes, `done` at cycle 6, `conflict`=0, `unit_count`=0.
- Clause 0 = (x1, ¬x2), x1=0 assigned, x2 unassigned → push at cycle 3 with `push_variable`=2, `push_val`=0, `unit_count`=1.
- Clause 2 of 5 has all literals false → `conflict`=1, `conflict_clause`=2 and `done` at cycle 5, no push at cycle 6, `mem_rd_en` low from cycle 5.
- Clauses 0 and 1 both unit on x3=1 → two pushes without `UCD_DEDUP_EN`. One push with it. Units x3=1 then x3=0 with it → conflict at clause 1.
- `clause_count`=0 → `done` at cycle 1. `reset` at cycle 2 of a 4-clause pass → no `push_en` afterwards, `busy`=0.
